// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver.
//   rx_state_t  : receiver FSM states (ST_PARITY only with UART_RX_PARITY_EN)
//   SAMPLE_LEAD : first vote sample sits SAMPLE_LEAD clocks before mid-bit
//   SAMPLE_LAG  : last vote sample / decision point sits SAMPLE_LAG after it
//   par_calc    : expected parity bit for a character (zero-extended to 9 bits)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_t;

  localparam int unsigned SAMPLE_LEAD = 1;
  localparam int unsigned SAMPLE_LAG  = 1;

  // Parity bit that makes XOR(data, parity) equal odd.
  function automatic logic par_calc(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Bit-period counter and 2-of-3 majority vote around mid-bit.
//   clk, n_rst : clock, asynchronous active-low reset
//   rxs        : synchronised serial line
//   clear      : hold the counter at 0 (receiver idle)
//   bit_strobe : counter is at the decision point H+SAMPLE_LAG
//   bit_val    : majority of the three mid-bit samples, valid with bit_strobe
//   wrap       : counter is at CLKS_PER_BIT-1 (last cycle of the bit)
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic rxs,
  input  logic clear,
  output logic bit_strobe,
  output logic bit_val,
  output logic wrap
);

  localparam int unsigned H  = CLKS_PER_BIT / 2;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;
  logic          s_lead;
  logic          s_mid;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt    <= '0;
      s_lead <= 1'b1;
      s_mid  <= 1'b1;
    end else begin
      if (clear || wrap) cnt <= '0;
      else               cnt <= cnt + CW'(1);
      if (cnt == CW'(H - SAMPLE_LEAD)) s_lead <= rxs;
      if (cnt == CW'(H))               s_mid  <= rxs;
    end
  end

  assign wrap       = (cnt == CW'(CLKS_PER_BIT - 1));
  assign bit_strobe = (cnt == CW'(H + SAMPLE_LAG));
  // Third sample is the live line value at the decision point.
  assign bit_val    = (s_lead & s_mid) | (s_lead & rxs) | (s_mid & rxs);

endmodule

// File: rtl/uart_rx_os.sv
// Parametrised oversampling UART receiver with a one-entry valid/ready buffer.
//   clk, n_rst : clock, asynchronous active-low reset
//   rxd        : serial line, idle high, asynchronous to clk
//   rx_data    : received character, rx_valid marks it unconsumed
//   rx_ready   : consumer accepts rx_data when rx_valid is 1
//   frame_err  : a stop bit of rx_data's frame was sampled low
//   parity_err : parity mismatch on rx_data's frame (0 without the macro)
//   overrun    : one-cycle pulse when a completed frame is dropped
// Optional feature: define UART_RX_PARITY_EN to expect one parity bit.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be even and at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_fmt
    $error("unsupported frame format parameters");
  end

  logic                 sync1, rxs;
  rx_state_t            state, state_nxt;
  logic                 armed;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           idx;
  logic                 ferr_cand;
  logic                 perr_new;
  logic                 bit_strobe, bit_val, wrap;
  logic                 shift_en, idx_inc, idx_clr, stop_en, complete;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
  logic                 par_en;
`endif

  uart_bit_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .clk        (clk),
    .n_rst      (n_rst),
    .rxs        (rxs),
    .clear      (state == ST_IDLE),
    .bit_strobe (bit_strobe),
    .bit_val    (bit_val),
    .wrap       (wrap)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    idx_inc   = 1'b0;
    idx_clr   = 1'b0;
    stop_en   = 1'b0;
    complete  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    case (state)
      ST_IDLE:  if (!rxs && armed) state_nxt = ST_START;
      ST_START: begin
        if (bit_strobe && bit_val) state_nxt = ST_IDLE;
        else if (wrap)             state_nxt = ST_DATA;
      end
      ST_DATA: if (bit_strobe) begin
        shift_en = 1'b1;
        if (idx == 4'(DATA_BITS - 1)) begin
          idx_clr = 1'b1;
`ifdef UART_RX_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end else begin
          idx_inc = 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (bit_strobe) begin
        par_en    = 1'b1;
        state_nxt = ST_STOP;
      end
`endif
      ST_STOP: if (bit_strobe) begin
        stop_en = 1'b1;
        // Finish at the decision point so the next start edge is caught.
        if (idx == 4'(STOP_BITS - 1)) begin
          complete  = 1'b1;
          idx_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          idx_inc = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign perr_new = (par_bit != par_calc(9'(shreg), 1'(PARITY_ODD)));
`else
  assign perr_new = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1      <= 1'b1;
      rxs        <= 1'b1;
      armed      <= 1'b0;
      shreg      <= '0;
      idx        <= '0;
      ferr_cand  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
      // Needs a high cycle while idle, so a held-low line cannot retrigger.
      armed <= (state == ST_IDLE) && (state_nxt == ST_IDLE) && (armed || rxs);
      if (shift_en) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
      if (state == ST_IDLE || idx_clr) idx <= '0;
      else if (idx_inc)                idx <= idx + 4'd1;
      if (state == ST_IDLE)           ferr_cand <= 1'b0;
      else if (stop_en && !bit_val)   ferr_cand <= 1'b1;
      overrun <= 1'b0;
      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          frame_err  <= ferr_cand | ~bit_val;
          parity_err <= perr_new;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      par_bit <= 1'b0;
    else if (par_en) par_bit <= bit_val;
  end
`endif

endmodule
